// File: rtl/cf_access_sequencer.sv
// Sequences 8-bit CompactFlash memory/attribute accesses with setup/strobe/hold timing,
// wait-line timeout and debounced card detect behind a req/done handshake.
module cf_access_sequencer #(
    parameter int T_SETUP   = 2,
    parameter int T_STROBE  = 4,
    parameter int T_HOLD    = 1,
    parameter int WAIT_MAX  = 255,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw_b,
    input  logic        reg_sel,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        card_present,
    output logic        cf_ce,
    output logic        cf_oe,
    output logic        cf_we,
    output logic        cf_reg,
    output logic [10:0] cf_address,
    output logic [7:0]  cf_dout,
    output logic        cf_dout_en,
    input  logic [7:0]  cf_din,
    input  logic        cf_wait_b,
    input  logic [1:0]  cf_cd
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]       wait_sync_q, wait_sync_d;
    logic [3:0]       cd_sync_q, cd_sync_d;
    logic             rw_q, rw_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             card_present_q, card_present_d;
    logic             cf_ce_q, cf_ce_d;
    logic             cf_oe_q, cf_oe_d;
    logic             cf_we_q, cf_we_d;
    logic             cf_reg_q, cf_reg_d;
    logic [10:0]      cf_address_q, cf_address_d;
    logic [7:0]       cf_dout_q, cf_dout_d;
    logic             cf_dout_en_q, cf_dout_en_d;

    logic wait_s;
    logic cd_raw;

    assign wait_s = wait_sync_q[1];
    assign cd_raw = ~cd_sync_q[2] & ~cd_sync_q[3];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        db_cnt_d       = db_cnt_q;
        wait_sync_d    = {wait_sync_q[0], cf_wait_b};
        cd_sync_d      = {cd_sync_q[1:0], cf_cd};
        rw_d           = rw_q;
        timeout_d      = timeout_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        rdata_d        = rdata_q;
        card_present_d = card_present_q;
        cf_ce_d        = cf_ce_q;
        cf_oe_d        = cf_oe_q;
        cf_we_d        = cf_we_q;
        cf_reg_d       = cf_reg_q;
        cf_address_d   = cf_address_q;
        cf_dout_d      = cf_dout_q;
        cf_dout_en_d   = cf_dout_en_q;

        if (cd_raw != card_present_q) begin
            if (db_cnt_q == DB_LAST) begin
                card_present_d = cd_raw;
                db_cnt_d       = '0;
            end else begin
                db_cnt_d = db_cnt_q + CNT_ONE;
            end
        end else begin
            db_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (card_present_q) begin
                        rw_d         = rw_b;
                        cf_reg_d     = reg_sel;
                        cf_address_d = addr;
                        cf_dout_d    = wdata;
                        cf_ce_d      = 1'b0;
                        cf_dout_en_d = ~rw_b;
                        busy_d       = 1'b1;
                        timeout_d    = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_SETUP;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                    cf_oe_d = ~rw_q;
                    cf_we_d = rw_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d = '0;
                    if (!wait_s) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_HOLD;
                        cf_oe_d = 1'b1;
                        cf_we_d = 1'b1;
                        if (rw_q) rdata_d = cf_din;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                // A wait release on the final allowed cycle still counts as success.
                if (wait_s || cnt_q == WAIT_LAST) begin
                    timeout_d = ~wait_s;
                    cnt_d     = '0;
                    state_d   = S_HOLD;
                    cf_oe_d   = 1'b1;
                    cf_we_d   = 1'b1;
                    if (rw_q) rdata_d = cf_din;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    cf_ce_d      = 1'b1;
                    cf_dout_en_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    err_d        = timeout_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Losing the card mid-access overrides everything and leaves rdata untouched.
        if (state_q != S_IDLE && !card_present_q) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            cf_ce_d      = 1'b1;
            cf_oe_d      = 1'b1;
            cf_we_d      = 1'b1;
            cf_dout_en_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            err_d        = 1'b1;
            rdata_d      = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            db_cnt_q       <= '0;
            wait_sync_q    <= 2'b11;
            cd_sync_q      <= 4'b1111;
            rw_q           <= 1'b1;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= 8'h00;
            card_present_q <= 1'b0;
            cf_ce_q        <= 1'b1;
            cf_oe_q        <= 1'b1;
            cf_we_q        <= 1'b1;
            cf_reg_q       <= 1'b1;
            cf_address_q   <= 11'h000;
            cf_dout_q      <= 8'h00;
            cf_dout_en_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            db_cnt_q       <= db_cnt_d;
            wait_sync_q    <= wait_sync_d;
            cd_sync_q      <= cd_sync_d;
            rw_q           <= rw_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
            card_present_q <= card_present_d;
            cf_ce_q        <= cf_ce_d;
            cf_oe_q        <= cf_oe_d;
            cf_we_q        <= cf_we_d;
            cf_reg_q       <= cf_reg_d;
            cf_address_q   <= cf_address_d;
            cf_dout_q      <= cf_dout_d;
            cf_dout_en_q   <= cf_dout_en_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign card_present = card_present_q;
    assign cf_ce        = cf_ce_q;
    assign cf_oe        = cf_oe_q;
    assign cf_we        = cf_we_q;
    assign cf_reg       = cf_reg_q;
    assign cf_address   = cf_address_q;
    assign cf_dout      = cf_dout_q;
    assign cf_dout_en   = cf_dout_en_q;

endmodule

// File: tb/tb_cf_access_sequencer.sv
// Bench for cf_access_sequencer: a CF card model on the pins, a reference memory for
// expected read data, and decoupled response/pin monitors fed from expectation queues.
module tb_cf_access_sequencer;

    localparam int TS   = 2;
    localparam int TST  = 4;
    localparam int TH   = 1;
    localparam int WMAX = 255;
    localparam int DB   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        rw_b = 1'b1;
    logic        reg_sel = 1'b0;
    logic [10:0] addr = 11'h000;
    logic [7:0]  wdata = 8'h00;
    logic        cf_wait_b = 1'b1;
    logic [1:0]  cf_cd = 2'b11;
    logic [7:0]  cf_din;
    logic        busy, done, err, card_present;
    logic [7:0]  rdata;
    logic        cf_ce, cf_oe, cf_we, cf_reg, cf_dout_en;
    logic [10:0] cf_address;
    logic [7:0]  cf_dout;

    cf_access_sequencer dut (
        .clk(clk), .reset(rst_n), .req(req), .rw_b(rw_b), .reg_sel(reg_sel),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .card_present(card_present), .cf_ce(cf_ce), .cf_oe(cf_oe),
        .cf_we(cf_we), .cf_reg(cf_reg), .cf_address(cf_address), .cf_dout(cf_dout),
        .cf_dout_en(cf_dout_en), .cf_din(cf_din), .cf_wait_b(cf_wait_b), .cf_cd(cf_cd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ce_len;
        int          stb_len;
        int          stb_start;
        logic        is_rd;
        logic [10:0] a;
        logic        rg;
        logic [7:0]  d;
        logic        chk_len;
    } acc_t;

    logic [9:0]  exp_q[$];
    acc_t        pin_q[$];
    logic [7:0]  ref_mem [0:2047];
    logic [7:0]  card_mem [0:2047];
    logic [7:0]  last_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input int act, input int req_v);
        n_chk++;
        if (act != req_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Card model: reads combinationally, writes while cf_we is low.
    assign cf_din = card_mem[cf_address];
    initial begin
        for (int i = 0; i < 2048; i++) card_mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(negedge clk);
            if (!cf_we) card_mem[cf_address] = cf_dout;
        end
    end

    logic [9:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("err", int'(err), int'(mon_e[9]));
                if (mon_e[8]) check("rdata", int'(rdata), int'(mon_e[7:0]));
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    int          ce_run, stb_run, stb_start;
    logic        seen, en_and, en_or, s_rd, s_rg;
    logic [10:0] s_a;
    logic [7:0]  s_d;
    acc_t        pr;
    always @(negedge clk) begin
        if (!rst_n) begin
            ce_run = 0; stb_run = 0; stb_start = 0; seen = 1'b0; en_and = 1'b1; en_or = 1'b0;
        end else begin
            check("oe_we_exclusive", int'(cf_oe | cf_we), 1);
            check("strobe_needs_ce", int'(!cf_ce || (cf_oe && cf_we)), 1);
            if (!cf_ce) begin
                ce_run++;
                en_and = en_and & cf_dout_en;
                en_or  = en_or | cf_dout_en;
                if (!cf_oe || !cf_we) begin
                    if (!seen) begin
                        seen = 1'b1; stb_start = ce_run; s_rd = !cf_oe;
                        s_a = cf_address; s_rg = cf_reg; s_d = cf_dout;
                    end
                    stb_run++;
                end
            end else if (ce_run > 0) begin
                check("done_at_ce_rise", int'(done), 1);
                if (pin_q.size() == 0) begin
                    check("unexpected_access", ce_run, 0);
                end else begin
                    pr = pin_q.pop_front();
                    if (pr.chk_len) begin
                        check("ce_low_cycles", ce_run, pr.ce_len);
                        check("strobe_low_cycles", stb_run, pr.stb_len);
                        check("strobe_start", stb_start, pr.stb_start);
                    end
                    check("strobe_kind", int'(s_rd), int'(pr.is_rd));
                    check("cf_address", int'(s_a), int'(pr.a));
                    check("cf_reg", int'(s_rg), int'(pr.rg));
                    if (pr.is_rd) begin
                        check("dout_en_read", int'(en_or), 0);
                    end else begin
                        check("dout_en_write", int'(en_and), 1);
                        check("cf_dout", int'(s_d), int'(pr.d));
                    end
                end
                ce_run = 0; stb_run = 0; stb_start = 0; seen = 1'b0; en_and = 1'b1; en_or = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, int'({cf_ce, cf_oe, cf_we, cf_reg, cf_dout_en, busy, done, err, card_present}),
              int'(9'b1111_00000));
        check({tag, "_addr"}, int'(cf_address), 0);
        check({tag, "_dout"}, int'(cf_dout), 0);
        check({tag, "_rdata"}, int'(rdata), 0);
    endtask

    task automatic push_pin(input logic rd, input logic [10:0] a, input logic rg, input logic [7:0] d,
                            input int stb, input logic chk_len);
        acc_t x;
        x.ce_len = TS + stb + TH; x.stb_len = stb; x.stb_start = TS + 1;
        x.is_rd = rd; x.a = a; x.rg = rg; x.d = d; x.chk_len = chk_len;
        pin_q.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        if (!done) check("done_timeout", int'(done), 1);
    endtask

    task automatic do_access(input logic rd, input logic [10:0] a, input logic rg, input logic [7:0] d,
                             input int extra, input logic stuck);
        int stb;
        stb = stuck ? TST + WMAX : TST + extra;
        if (rd) begin
            last_rd = ref_mem[a];
            exp_q.push_back({stuck, 1'b1, ref_mem[a]});
        end else begin
            ref_mem[a] = d;
            exp_q.push_back({stuck, 1'b0, 8'h00});
        end
        push_pin(rd, a, rg, d, stb, 1'b1);
        @(negedge clk);
        cf_wait_b = (stuck || extra > 0) ? 1'b0 : 1'b1;
        rw_b = rd; addr = a; reg_sel = rg; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        // Wait pin is seen by the sequencer two clocks late through its synchroniser.
        if (!stuck && extra > 0) begin
            repeat (TS + TST + extra - 3) @(posedge clk);
            #1 cf_wait_b = 1'b1;
        end
        wait_done(TS + stb + TH + 10);
        cf_wait_b = 1'b1;
    endtask

    int          k;
    logic        stay;
    logic        r_rd, r_rg;
    logic [10:0] r_a;
    logic [7:0]  r_d;
    int          r_ex;

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        last_rd = 8'h00;

        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        exp_q.push_back({1'b1, 1'b0, 8'h00});
        @(negedge clk);
        rw_b = 1'b1; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("nocard_done", int'(done), 1);
        check("nocard_err", int'(err), 1);
        repeat (3) begin
            check("nocard_pins", int'({cf_ce, cf_oe, cf_we}), 7);
            @(negedge clk);
        end

        cf_cd = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (!card_present && k < 60);
        check("insert_delay", k, 2 + DB);

        cf_cd = 2'b11;
        repeat (5) @(negedge clk);
        cf_cd = 2'b00;
        stay = 1'b1;
        repeat (25) begin @(negedge clk); stay = stay & card_present; end
        check("glitch_ignored", int'(stay), 1);

        do_access(1'b0, 11'h200, 1'b0, 8'hA5, 0, 1'b0);
        do_access(1'b0, 11'h055, 1'b1, 8'h3C, 0, 1'b0);
        do_access(1'b1, 11'h055, 1'b1, 8'h00, 10, 1'b0);
        do_access(1'b1, 11'h200, 1'b0, 8'h00, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_a  = 11'($urandom_range(0, 15));
            r_rg = 1'($urandom_range(0, 1));
            r_d  = 8'($urandom);
            r_ex = int'($urandom_range(0, 4));
            do_access(r_rd, r_a, r_rg, r_d, r_ex, 1'b0);
        end

        exp_q.push_back({1'b1, 1'b1, last_rd});
        push_pin(1'b1, 11'h123, 1'b0, 8'h00, 0, 1'b0);
        @(negedge clk);
        cf_wait_b = 1'b0; rw_b = 1'b1; addr = 11'h123; reg_sel = 1'b0; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (cf_oe && k < 20);
        check("remove_strobe_seen", int'(cf_oe), 0);
        cf_cd = 2'b11;
        k = 0;
        do begin @(negedge clk); k++; end while (card_present && k < 60);
        check("remove_cp_fell", int'(card_present), 0);
        @(negedge clk);
        check("remove_pins", int'({cf_ce, cf_oe, cf_we, cf_dout_en}), 14);
        check("remove_done_err", int'({done, err}), 3);
        cf_wait_b = 1'b1;

        repeat (3) @(negedge clk);
        cf_cd = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (!card_present && k < 60);
        check("reinsert", int'(card_present), 1);
        check("exp_q_drained", exp_q.size(), 0);
        check("pin_q_drained", pin_q.size(), 0);

        @(negedge clk);
        cf_wait_b = 1'b0; rw_b = 1'b0; addr = 11'h3FF; wdata = 8'h77; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (cf_we && k < 20);
        check("rst_mid_strobe", int'(cf_we), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        exp_q.delete();
        pin_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cf_wait_b = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cf_access_sequencer.md
Name: cf_access_sequencer

Overview:
- Clocked controller that sequences 8-bit CompactFlash memory/attribute accesses on the minibus CPLD.
- Replaces direct ale/oe/rw_b pass-through with a request/done handshake and parameterised setup/strobe/hold timing.
- Honours the card's wait line with a timeout and debounces card detect, so accesses are never issued to an absent card.

Parameters:
- T_SETUP, 2: cycles from cf_ce low/address valid to strobe assertion (min 1).
- T_STROBE, 4: minimum cycles that cf_oe/cf_we is held low (min 1).
- T_HOLD, 1: cycles with the strobe high while cf_ce, address and data are still held (min 1).
- WAIT_MAX, 255: maximum extra strobe cycles while cf_wait_b is low before timeout.
- DB_CYCLES, 16: stable cycles required after synchronisation before card_present changes.
- CNT_W, 8: width of the timing and debounce counters; must hold every parameter value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- req  in  1  access request; sampled only in IDLE
- rw_b  in  1  1 = read, 0 = write
- reg_sel  in  1  drives cf_reg: 0 = attribute/IO, 1 = common memory
- addr  in  11  CF address
- wdata  in  8  write data
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: no card, wait timeout, or card removed
- rdata  out  8  read data; valid from done onward until the next read completes
- card_present  out  1  debounced card detect
- cf_ce  out  1  active-low card enable
- cf_oe  out  1  active-low output enable
- cf_we  out  1  active-low write enable
- cf_reg  out  1  register/attribute select
- cf_address  out  11  CF address
- cf_dout  out  8  CF write data
- cf_dout_en  out  1  CF data bus drive enable
- cf_din  in  8  CF read data
- cf_wait_b  in  1  active-low wait; asynchronous, synchronised by 2 flops internally
- cf_cd  in  2  active-low card detect pins; asynchronous, synchronised by 2 flops internally

Behaviour:
- Reset state:
  - cf_ce = cf_oe = cf_we = cf_reg = 1.
  - cf_address = 0, cf_dout = 0, cf_dout_en = 0.
  - busy = done = err = 0, rdata = 0, card_present = 0.
  - FSM in IDLE, all counters 0.
- Debounce:
  - raw = ~cd_sync[0] & ~cd_sync[1].
  - If raw != card_present, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES-1 with raw still differing, card_present takes raw and the counter clears.
- FSM states: IDLE, SETUP, STROBE, WAIT, HOLD.
- IDLE:
  - req=1 and card_present=1 at edge N: latch rw_b, reg_sel, addr, wdata. From N+1: cf_ce=0, cf_address/cf_reg driven, busy=1, cf_dout_en=rw_b?0:1. Go to SETUP.
  - req=1 and card_present=0: next cycle done=1, err=1; no CF pin toggles; stay in IDLE.
- SETUP: hold for T_SETUP cycles, then STROBE.
- STROBE:
  - Drive cf_oe=0 (read) or cf_we=0 (write) for T_STROBE cycles.
  - After the T_STROBE cycles: if the synchronised wait is low, go to WAIT; otherwise release the strobe and go to HOLD.
- WAIT:
  - Strobe stays low.
  - Wait goes high: release the strobe and go to HOLD.
  - WAIT_MAX cycles elapse: release the strobe, go to HOLD, and set err for this access.
- Read capture: rdata <= cf_din on the edge where the strobe deasserts.
- HOLD:
  - cf_ce, address and data held for T_HOLD cycles.
  - Then return to IDLE with cf_ce=1, cf_dout_en=0, busy=0, and done=1 for exactly one cycle. err is 1 only on timeout.
- No-wait latency: done is high in cycle N+1+T_SETUP+T_STROBE+T_HOLD.
- Card removal: card_present falling in any non-IDLE state aborts on the next edge. All strobes and cf_ce go high, cf_dout_en=0, done=1, err=1, return to IDLE. rdata is not updated.
- req is ignored while busy. A req held high through done starts a new access in the cycle after done.
- cf_oe and cf_we are never low simultaneously. The strobe never falls while cf_ce is high.

Test Plan:
- Card insertion: cf_cd=2'b00 held 20 cycles -> card_present rises 2+DB_CYCLES cycles after the change. A 5-cycle glitch to 2'b11 -> card_present unchanged.
- Write (defaults, cf_wait_b=1): addr=0x200, wdata=0xA5, reg_sel=0 ->
  - cf_ce low 7 cycles; cf_we low exactly 4 cycles, starting 2 cycles after cf_ce falls.
  - cf_dout=0xA5 with cf_dout_en=1 throughout; cf_reg=0.
  - done 1 cycle, err=0.
- Read, cf_din=0x3C, wait held low 10 cycles past the minimum strobe -> cf_oe low 14 cycles, rdata=0x3C at done, err=0.
- Wait stuck low -> cf_oe low exactly T_STROBE+WAIT_MAX cycles, then done=1, err=1, cf_ce returns high.
- req with card_present=0 -> done=1, err=1 one cycle later; cf_ce/cf_oe/cf_we never leave 1.
- Card removed during STROBE -> within 1 cycle of card_present falling: all strobes and cf_ce high, done=err=1. Async reset asserted mid-access -> every output at its reset value immediately, without waiting for a clock edge.
